// File: rtl/biquad_filter_mc.sv
// Multi-channel direct-form-I biquad built around one shared multiplier.
// Each sample takes five MAC cycles and one output cycle.
module biquad_filter_mc #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 16,
  parameter int FRAC     = 14,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] y,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  output logic                     sat,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     hist_clr
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 3;
  localparam logic signed [ACC_W-1:0]  Y_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  Y_MIN = ~Y_MAX;
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t state, state_nx;
  logic [2:0]               mac_idx;
  logic signed [DATA_W-1:0] x_lat;
  logic [CH_W-1:0]          ch_lat;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] b0, b1, b2, a1, a2;
  logic signed [DATA_W-1:0] hx1 [CHANNELS];
  logic signed [DATA_W-1:0] hx2 [CHANNELS];
  logic signed [DATA_W-1:0] hy1 [CHANNELS];
  logic signed [DATA_W-1:0] hy2 [CHANNELS];

  logic                     transfer;
  logic                     ch_ok;
  logic signed [COEF_W-1:0] mul_c;
  logic signed [DATA_W-1:0] mul_d;
  logic                     mul_sub;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] y_clip;
  logic                     sat_clip;

  assign transfer = in_valid && (state == IDLE);
  // Out-of-range channels still flow through the pipeline but never touch history.
  assign ch_ok    = ({{(32 - CH_W){1'b0}}, ch_lat} < 32'(CHANNELS));

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (transfer) state_nx = MAC; else state_nx = IDLE;
      MAC:     if (mac_idx == 3'd4) state_nx = OUT; else state_nx = MAC;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == IDLE);
    end
  end

  // Shared-multiplier operand select: feed-forward terms add, feedback terms subtract.
  always_comb begin
    mul_c   = '0;
    mul_d   = '0;
    mul_sub = 1'b0;
    if (ch_ok) begin
      case (mac_idx)
        3'd0: begin mul_c = b0; mul_d = x_lat; end
        3'd1: begin mul_c = b1; mul_d = hx1[ch_lat]; end
        3'd2: begin mul_c = b2; mul_d = hx2[ch_lat]; end
        3'd3: begin mul_c = a1; mul_d = hy1[ch_lat]; mul_sub = 1'b1; end
        3'd4: begin mul_c = a2; mul_d = hy2[ch_lat]; mul_sub = 1'b1; end
        default: begin mul_c = '0; mul_d = '0; mul_sub = 1'b0; end
      endcase
    end else begin
      mul_c   = '0;
      mul_d   = '0;
      mul_sub = 1'b0;
    end
  end

  assign prod     = mul_c * mul_d;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc >>> FRAC;

  // Saturate the scaled accumulator to the output range.
  always_comb begin
    y_clip   = '0;
    sat_clip = 1'b0;
    if (!ch_ok) begin
      y_clip   = '0;
      sat_clip = 1'b0;
    end else if (shifted > Y_MAX) begin
      y_clip   = Y_MAX[DATA_W-1:0];
      sat_clip = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_clip   = Y_MIN[DATA_W-1:0];
      sat_clip = 1'b1;
    end else begin
      y_clip   = shifted[DATA_W-1:0];
      sat_clip = 1'b0;
    end
  end

  // Datapath: coefficient bank, history, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_idx   <= 3'd0;
      x_lat     <= '0;
      ch_lat    <= '0;
      acc       <= '0;
      y         <= '0;
      sat       <= 1'b0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      b0        <= UNITY;
      b1        <= '0;
      b2        <= '0;
      a1        <= '0;
      a2        <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hx1[i] <= '0;
        hx2[i] <= '0;
        hy1[i] <= '0;
        hy2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we) begin
            case (coef_addr)
              3'd0:    b0 <= coef_wdata;
              3'd1:    b1 <= coef_wdata;
              3'd2:    b2 <= coef_wdata;
              3'd3:    a1 <= coef_wdata;
              3'd4:    a2 <= coef_wdata;
              default: ;
            endcase
          end
          if (hist_clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
              hx1[i] <= '0;
              hx2[i] <= '0;
              hy1[i] <= '0;
              hy2[i] <= '0;
            end
          end
          if (transfer) begin
            x_lat   <= x;
            ch_lat  <= in_ch;
            acc     <= '0;
            mac_idx <= 3'd0;
          end
        end
        MAC: begin
          acc     <= mul_sub ? (acc - prod_ext) : (acc + prod_ext);
          mac_idx <= mac_idx + 3'd1;
        end
        OUT: begin
          out_valid <= 1'b1;
          y         <= y_clip;
          sat       <= sat_clip;
          out_ch    <= ch_lat;
          if (ch_ok) begin
            hx2[ch_lat] <= hx1[ch_lat];
            hx1[ch_lat] <= x_lat;
            hy2[ch_lat] <= hy1[ch_lat];
            hy1[ch_lat] <= y_clip;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_filter_mc.sv
// Directed bench for biquad_filter_mc: hand-computed vectors for pass-through,
// scaling, saturation, channel isolation, feedback, history clear and abort-on-reset.
module tb_biquad_filter_mc;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] x;
  logic [0:0]        in_ch;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] y;
  logic [0:0]        out_ch;
  logic              out_valid;
  logic              sat;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [15:0]       coef_wdata;
  logic              hist_clr;

  int checks = 0;
  int errors = 0;

  biquad_filter_mc #(.DATA_W(8), .COEF_W(16), .FRAC(14), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .x(x), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .out_ch(out_ch), .out_valid(out_valid),
    .sat(sat), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .hist_clr(hist_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input logic [2:0] addr, input int val);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = 16'(val);
    @(posedge clk);
    #1;
    coef_we    = 1'b0;
  endtask

  task automatic clear_hist();
    @(negedge clk);
    hist_clr = 1'b1;
    @(posedge clk);
    #1;
    hist_clr = 1'b0;
  endtask

  // Transfer one sample (optionally with a same-cycle history clear) and check the result.
  task automatic send(input string tag, input int ch, input int xv, input int exp_y,
                      input int exp_sat, input bit clr);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_ready"}, int'(in_ready), 1);
    x        = 8'(xv);
    in_ch    = 1'(ch);
    in_valid = 1'b1;
    hist_clr = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hist_clr = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check_val({tag, "_lat"}, n, 6);
    check_val({tag, "_y"}, int'(y), exp_y);
    check_val({tag, "_sat"}, int'(sat), exp_sat);
    check_val({tag, "_ch"}, int'(out_ch), ch);
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    int pulses;
    rst        = 1'b1;
    x          = '0;
    in_ch      = '0;
    in_valid   = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    hist_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", int'(in_ready), 1);
    check_val("rst_valid", int'(out_valid), 0);
    check_val("rst_y", int'(y), 0);
    check_val("rst_sat", int'(sat), 0);
    check_val("rst_ch", int'(out_ch), 0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through after reset
    send("pt10", 0, 10, 10, 0, 1'b0);
    send("ptm20", 0, -20, -20, 0, 1'b0);

    // Half gain with floor rounding
    write_coef(3'd0, 8192);
    send("half50", 0, 50, 25, 0, 1'b0);
    send("halfm5", 0, -5, -3, 0, 1'b0);

    // Near-double gain saturates both ways
    write_coef(3'd0, 32767);
    send("satp", 0, 100, 127, 1, 1'b0);
    send("satn", 0, -100, -128, 1, 1'b0);

    // Pure one-sample delay, interleaved channels
    write_coef(3'd0, 0);
    write_coef(3'd1, 16384);
    clear_hist();
    send("dly0a", 0, 7, 0, 0, 1'b0);
    send("dly1a", 1, 9, 0, 0, 1'b0);
    send("dly0b", 0, 1, 7, 0, 1'b0);
    send("dly1b", 1, 0, 9, 0, 1'b0);

    // First-order feedback decay, then same-cycle clear
    write_coef(3'd0, 16384);
    write_coef(3'd1, 0);
    write_coef(3'd3, -8192);
    clear_hist();
    send("iir64", 0, 64, 64, 0, 1'b0);
    send("iir32", 0, 0, 32, 0, 1'b0);
    send("iir16", 0, 0, 16, 0, 1'b0);
    send("iirclr", 0, 0, 0, 0, 1'b1);

    // Reset sampled on the third MAC cycle aborts the sample
    @(negedge clk);
    x        = 8'sd50;
    in_ch    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_ready", int'(in_ready), 1);
    check_val("abort_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check_val("abort_pulses", pulses, 0);
    send("abort_pt", 0, 10, 10, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
